// File: rtl/wei_line_fetch.sv
// Weight line fetcher: serves regfile line requests from SRAM_WEI in BEAT_WORDS-wide beats, zero-pads out-of-range lines.
// Optional WEI_PREFETCH_EN: background fetch of line N+1 into a shadow buffer after delivering line N.
module wei_line_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int WR_NUM     = 8,
    parameter int BEAT_WORDS = 4,
    parameter int SRAM_AW    = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             reset,
    input  logic [SRAM_AW-1:0]               cfg_base,
    input  logic [ADDR_WIDTH-1:0]            cfg_num_lines,
    input  logic                             line_rdy,
    input  logic [ADDR_WIDTH-1:0]            line_addr,
    output logic                             line_val,
    output logic [DATA_WIDTH*WR_NUM-1:0]     line_data,
    output logic                             sram_rd_en,
    output logic [SRAM_AW-1:0]               sram_addr,
    input  logic [DATA_WIDTH*BEAT_WORDS-1:0] sram_rd_data,
    output logic                             busy
);
    localparam int BEATS  = WR_NUM / BEAT_WORDS;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W = DATA_WIDTH * WR_NUM;
    localparam int BEAT_W = DATA_WIDTH * BEAT_WORDS;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DRAIN, DELIVER, PAD
`ifdef WEI_PREFETCH_EN
        , PF_WAIT
`endif
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [BW-1:0]           beat;
    logic [BW-1:0]           rd_idx;
    logic                    rd_pend;
    logic [LINE_W-1:0]       line_buf;
    logic [LINE_W-1:0]       asm_next;
    logic [SRAM_AW-1:0]      line_off;
    logic                    load_line;
    logic                    clear_line;

`ifdef WEI_PREFETCH_EN
    logic pf_live;   // prefetch targets req_addr (issuing, in flight or complete)
    logic pf_run;    // background beats still to be issued
    logic pf_valid;  // shadow line complete
    logic pf_hit;
    logic pf_miss;
    logic pf_done;
    logic nxt_line_ok;

    assign pf_hit      = pf_live && (line_addr == req_addr);
    assign pf_miss     = (state == IDLE) && line_rdy && !pf_hit;
    assign pf_done     = pf_valid || (pf_live && rd_pend && (rd_idx == LAST_BEAT));
    assign nxt_line_ok = ((ADDR_WIDTH+1)'(req_addr) + (ADDR_WIDTH+1)'(1)) < (ADDR_WIDTH+1)'(cfg_num_lines);
    assign sram_rd_en  = (state == FETCH) ||
                         (pf_run && (((state == IDLE) && !pf_miss) || (state == PF_WAIT)));
`else
    assign sram_rd_en  = (state == FETCH);
`endif

    assign line_off  = SRAM_AW'(req_addr * BEATS);
    assign sram_addr = sram_rd_en ? (cfg_base + line_off + SRAM_AW'(beat)) : '0;
    assign line_val  = (state == DELIVER) || (state == PAD);
    assign busy      = (state != IDLE);

    // Read data returns one cycle after its strobe; merge it into the line being assembled.
    always_comb begin
        asm_next = line_buf;
        if (rd_pend)
            asm_next[rd_idx*BEAT_W +: BEAT_W] = sram_rd_data;
    end

    always_comb begin
        state_nxt  = state;
        load_line  = 1'b0;
        clear_line = 1'b0;
        case (state)
            IDLE: begin
                if (line_rdy) begin
`ifdef WEI_PREFETCH_EN
                    if (pf_hit) begin
                        if (pf_done) begin
                            state_nxt = DELIVER;
                            load_line = 1'b1;
                        end else begin
                            state_nxt = PF_WAIT;
                        end
                    end else
`endif
                    if (line_addr < cfg_num_lines) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt  = PAD;
                        clear_line = 1'b1;
                    end
                end
            end
            FETCH:   if (beat == LAST_BEAT) state_nxt = DRAIN;
            DRAIN: begin
                state_nxt = DELIVER;
                load_line = 1'b1;
            end
            DELIVER: state_nxt = IDLE;
            PAD:     state_nxt = IDLE;
`ifdef WEI_PREFETCH_EN
            PF_WAIT: begin
                if (pf_done) begin
                    state_nxt = DELIVER;
                    load_line = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_addr  <= '0;
            beat      <= '0;
            rd_idx    <= '0;
            rd_pend   <= 1'b0;
            line_buf  <= '0;
            line_data <= '0;
        end else if (reset) begin
            state     <= IDLE;
            req_addr  <= '0;
            beat      <= '0;
            rd_idx    <= '0;
            rd_pend   <= 1'b0;
            line_buf  <= '0;
            line_data <= '0;
        end else begin
            state    <= state_nxt;
            line_buf <= asm_next;
            rd_pend  <= sram_rd_en;
            rd_idx   <= beat;
            if (sram_rd_en)
                beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            if ((state == IDLE) && line_rdy)
                req_addr <= line_addr;
            if (load_line)
                line_data <= asm_next;
            else if (clear_line)
                line_data <= '0;
`ifdef WEI_PREFETCH_EN
            // A miss abandons the shadow: drop the pending return and restart the beat count.
            if (pf_miss) begin
                rd_pend <= 1'b0;
                beat    <= '0;
            end
            if ((state == DELIVER) && nxt_line_ok) begin
                req_addr <= req_addr + 1'b1;
                beat     <= '0;
            end
`endif
        end
    end

`ifdef WEI_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_live  <= 1'b0;
            pf_run   <= 1'b0;
            pf_valid <= 1'b0;
        end else if (reset) begin
            pf_live  <= 1'b0;
            pf_run   <= 1'b0;
            pf_valid <= 1'b0;
        end else if (pf_miss || (load_line && (state != DRAIN))) begin
            pf_live  <= 1'b0;
            pf_run   <= 1'b0;
            pf_valid <= 1'b0;
        end else if ((state == DELIVER) && nxt_line_ok) begin
            pf_live  <= 1'b1;
            pf_run   <= 1'b1;
            pf_valid <= 1'b0;
        end else begin
            if (sram_rd_en && (state != FETCH) && (beat == LAST_BEAT))
                pf_run <= 1'b0;
            if (pf_done)
                pf_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wei_line_fetch.sv
// Directed self-checking bench for wei_line_fetch with a 1-cycle-latency SRAM model.
module tb_wei_line_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        reset;
    logic [9:0]  cfg_base;
    logic [11:0] cfg_num_lines;
    logic        line_rdy;
    logic [11:0] line_addr;
    logic        line_val;
    logic [63:0] line_data;
    logic        sram_rd_en;
    logic [9:0]  sram_addr;
    logic [31:0] sram_rd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          n_rd;
    logic [9:0]  rd_addr [8];
    int          rd_cyc  [8];
    logic        busy_c1;

    // Hand-derived line images for cfg_base=0x100 (beat word j at address a is a[7:0]^j).
    localparam logic [63:0] LINE0_100 = 64'h0203000103020100;
    localparam logic [63:0] LINE1_100 = 64'h0001020301000302;
    localparam logic [63:0] LINE2_100 = 64'h0607040507060504;
    localparam logic [63:0] LINE3_100 = 64'h0405060705040706;
    localparam logic [63:0] LINE0_3FF = 64'h03020100FCFDFEFF;

`ifdef WEI_PREFETCH_EN
    localparam int EXP_SPACING = 4;
    localparam int EXP_B2B_LAT = 3;
`else
    localparam int EXP_SPACING = 5;
    localparam int EXP_B2B_LAT = 4;
`endif

    wei_line_fetch #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(12),
        .WR_NUM(8),
        .BEAT_WORDS(4),
        .SRAM_AW(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reset(reset),
        .cfg_base(cfg_base),
        .cfg_num_lines(cfg_num_lines),
        .line_rdy(line_rdy),
        .line_addr(line_addr),
        .line_val(line_val),
        .line_data(line_data),
        .sram_rd_en(sram_rd_en),
        .sram_addr(sram_addr),
        .sram_rd_data(sram_rd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_beat(input logic [9:0] a);
        return {4{a[7:0]}} ^ 32'h03020100;
    endfunction

    always @(posedge clk)
        sram_rd_data <= sram_rd_en ? mem_beat(sram_addr) : 32'hDEADBEEF;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    // Raise rdy for one cycle (cycle 0) and wait up to 20 cycles for line_val; lat stays -1 on timeout.
    task automatic do_request(input logic [11:0] a, output int lat, output logic [63:0] d, output int vt);
        n_rd = 0; lat = -1; d = '0; vt = -1; busy_c1 = 1'b0;
        line_rdy = 1'b1; line_addr = a;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            line_rdy = 1'b0;
            if (c == 1) busy_c1 = busy;
            if (sram_rd_en) begin
                if (n_rd < 8) begin
                    rd_addr[n_rd] = sram_addr;
                    rd_cyc[n_rd]  = c;
                end
                n_rd++;
            end
            if (line_val) begin
                lat = c; d = line_data; vt = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reset = 1'b0; line_rdy = 1'b0; line_addr = '0;
        cfg_base = 10'h100; cfg_num_lines = 12'd4;
        step(3);
        checks++; if (line_val !== 1'b0) begin errors++; $display("FAIL reset_line_val got %b want 0", line_val); end
        checks++; if (line_data !== 64'h0) begin errors++; $display("FAIL reset_line_data got %h want 0", line_data); end
        checks++; if (sram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_sram_rd_en got %b want 0", sram_rd_en); end
        checks++; if (sram_addr !== 10'h0) begin errors++; $display("FAIL reset_sram_addr got %h want 0", sram_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_fetch();
        int lat, vt; logic [63:0] d;
        sync_reset();
        cfg_base = 10'h100; cfg_num_lines = 12'd4;
        do_request(12'd2, lat, d, vt);
        checks++; if (n_rd !== 2) begin errors++; $display("FAIL t1_num_reads got %0d want 2", n_rd); end
        checks++; if (rd_addr[0] !== 10'h104 || rd_cyc[0] !== 1) begin errors++; $display("FAIL t1_beat0 got %h@%0d want 104@1", rd_addr[0], rd_cyc[0]); end
        checks++; if (rd_addr[1] !== 10'h105 || rd_cyc[1] !== 2) begin errors++; $display("FAIL t1_beat1 got %h@%0d want 105@2", rd_addr[1], rd_cyc[1]); end
        checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", busy_c1); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL t1_latency got %0d want 4", lat); end
        checks++; if (d !== LINE2_100) begin errors++; $display("FAIL t1_data got %h want %h", d, LINE2_100); end
        step(1);
        checks++; if (line_val !== 1'b0) begin errors++; $display("FAIL t1_pulse_width got %b want 0", line_val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after got %b want 0", busy); end
        checks++; if (line_data !== LINE2_100) begin errors++; $display("FAIL t1_data_hold got %h want %h", line_data, LINE2_100); end
    endtask

    task automatic test_pad();
        int lat, vt; logic [63:0] d;
        sync_reset();
        cfg_base = 10'h100; cfg_num_lines = 12'd4;
        do_request(12'd4, lat, d, vt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL t2_latency got %0d want 1", lat); end
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL t2_data got %h want 0", d); end
        checks++; if (n_rd !== 0) begin errors++; $display("FAIL t2_num_reads got %0d want 0", n_rd); end
        step(1);
        checks++; if (line_val !== 1'b0) begin errors++; $display("FAIL t2_pulse_width got %b want 0", line_val); end
    endtask

    task automatic test_wrap();
        int lat, vt; logic [63:0] d;
        sync_reset();
        cfg_base = 10'h3FF; cfg_num_lines = 12'd4;
        do_request(12'd0, lat, d, vt);
        checks++; if (n_rd !== 2) begin errors++; $display("FAIL t3_num_reads got %0d want 2", n_rd); end
        checks++; if (rd_addr[0] !== 10'h3FF) begin errors++; $display("FAIL t3_addr0 got %h want 3ff", rd_addr[0]); end
        checks++; if (rd_addr[1] !== 10'h000) begin errors++; $display("FAIL t3_addr1 got %h want 000", rd_addr[1]); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL t3_latency got %0d want 4", lat); end
        checks++; if (d !== LINE0_3FF) begin errors++; $display("FAIL t3_data got %h want %h", d, LINE0_3FF); end
        step(1);
    endtask

    task automatic test_reset_mid_fetch();
        int lat, vt, vals; logic [63:0] d;
        sync_reset();
        cfg_base = 10'h100; cfg_num_lines = 12'd4;
        line_rdy = 1'b1; line_addr = 12'd2;
        step(1);
        line_rdy = 1'b0;
        checks++; if (sram_rd_en !== 1'b1) begin errors++; $display("FAIL t4_fetch_started got %b want 1", sram_rd_en); end
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || sram_rd_en !== 1'b0) begin errors++; $display("FAIL t4_aborted got busy=%b rd=%b want 0 0", busy, sram_rd_en); end
        vals = 0;
        for (int i = 0; i < 6; i++) begin
            if (line_val) vals++;
            step(1);
        end
        checks++; if (vals !== 0) begin errors++; $display("FAIL t4_no_val got %0d pulses want 0", vals); end
        do_request(12'd1, lat, d, vt);
        checks++; if (lat !== 4) begin errors++; $display("FAIL t4_latency got %0d want 4", lat); end
        checks++; if (d !== LINE1_100) begin errors++; $display("FAIL t4_data got %h want %h", d, LINE1_100); end
        step(1);
    endtask

    task automatic test_back_to_back();
        int lat0, lat1, lat2, vt0, vt1, vt2; logic [63:0] d0, d1, d2;
        sync_reset();
        cfg_base = 10'h100; cfg_num_lines = 12'd4;
        do_request(12'd0, lat0, d0, vt0);
        step(1);
        do_request(12'd1, lat1, d1, vt1);
        step(1);
        do_request(12'd2, lat2, d2, vt2);
        checks++; if (lat0 !== 4) begin errors++; $display("FAIL t5_lat0 got %0d want 4", lat0); end
        checks++; if (lat1 !== EXP_B2B_LAT || lat2 !== EXP_B2B_LAT) begin errors++; $display("FAIL t5_lat12 got %0d,%0d want %0d", lat1, lat2, EXP_B2B_LAT); end
        checks++; if (d0 !== LINE0_100) begin errors++; $display("FAIL t5_data0 got %h want %h", d0, LINE0_100); end
        checks++; if (d1 !== LINE1_100) begin errors++; $display("FAIL t5_data1 got %h want %h", d1, LINE1_100); end
        checks++; if (d2 !== LINE2_100) begin errors++; $display("FAIL t5_data2 got %h want %h", d2, LINE2_100); end
        checks++; if (vt1 - vt0 !== EXP_SPACING) begin errors++; $display("FAIL t5_spacing01 got %0d want %0d", vt1 - vt0, EXP_SPACING); end
        checks++; if (vt2 - vt1 !== EXP_SPACING) begin errors++; $display("FAIL t5_spacing12 got %0d want %0d", vt2 - vt1, EXP_SPACING); end
        step(1);
    endtask

`ifdef WEI_PREFETCH_EN
    task automatic test_prefetch();
        int lat, vt; logic [63:0] d;
        sync_reset();
        cfg_base = 10'h100; cfg_num_lines = 12'd4;
        do_request(12'd0, lat, d, vt);
        checks++; if (lat !== 4 || d !== LINE0_100) begin errors++; $display("FAIL t6_first got %0d %h want 4 %h", lat, d, LINE0_100); end
        step(5);
        do_request(12'd1, lat, d, vt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL t6_hit_latency got %0d want 1", lat); end
        checks++; if (d !== LINE1_100) begin errors++; $display("FAIL t6_hit_data got %h want %h", d, LINE1_100); end
        checks++; if (n_rd !== 0) begin errors++; $display("FAIL t6_hit_reads got %0d want 0", n_rd); end
        step(5);
        do_request(12'd3, lat, d, vt);
        checks++; if (lat !== 4) begin errors++; $display("FAIL t6_miss_latency got %0d want 4", lat); end
        checks++; if (d !== LINE3_100) begin errors++; $display("FAIL t6_miss_data got %h want %h", d, LINE3_100); end
        checks++; if (n_rd !== 2 || rd_addr[0] !== 10'h106) begin errors++; $display("FAIL t6_miss_reads got %0d@%h want 2@106", n_rd, rd_addr[0]); end
        step(1);
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_pad();
        test_wrap();
        test_reset_mid_fetch();
        test_back_to_back();
`ifdef WEI_PREFETCH_EN
        test_prefetch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
